// File: rtl/skin_bbox_if.sv
// rtl/skin_bbox_if.sv - mask stream in / bounding-box result out bundle for skin_bbox
//
// Purpose : groups the skin-mask input stream and the per-frame result bus
//           into one interface so the block connects with a single port.
// Signals : data_in_valid  mask pixel present this cycle
//           frame_start    current valid pixel is pixel (0,0) of a new frame
//           mask_in        1 = skin pixel
//           x_min, x_max   bounding-box columns of last completed frame (12b)
//           y_min, y_max   bounding-box rows of last completed frame (12b)
//           pixel_count    skin pixels in last completed frame (24b)
//           bbox_found     last completed frame contained a detection
//           bbox_valid     one-cycle pulse: result outputs just updated
// Modports: master = mask source / result consumer, slave = skin_bbox
interface skin_bbox_if;
  logic        data_in_valid;
  logic        frame_start;
  logic        mask_in;
  logic [11:0] x_min;
  logic [11:0] x_max;
  logic [11:0] y_min;
  logic [11:0] y_max;
  logic [23:0] pixel_count;
  logic        bbox_found;
  logic        bbox_valid;

  modport master (
    output data_in_valid, frame_start, mask_in,
    input  x_min, x_max, y_min, y_max, pixel_count, bbox_found, bbox_valid
  );

  modport slave (
    input  data_in_valid, frame_start, mask_in,
    output x_min, x_max, y_min, y_max, pixel_count, bbox_found, bbox_valid
  );
endinterface

// File: rtl/skin_bbox.sv
// rtl/skin_bbox.sv - per-frame bounding box and pixel count of a binary skin mask
//
// Purpose : accumulates, over one raster-order frame of valid-qualified mask
//           pixels, the min/max column and row of all skin pixels and their
//           count, and publishes one registered result per completed frame.
//           Results hold until the next frame completes.
// Ports   : clk  - pipeline clock
//           rst  - asynchronous, active-high reset
//           bus  - skin_bbox_if.slave (mask stream in, result bus out)
// Params  : IMG_WIDTH (2..4095), IMG_HEIGHT (2..4095), MIN_PIXELS
// Config  : SKIN_BBOX_NOISE_FILTER_EN - when defined, a frame counts as a
//           detection only if its skin-pixel count reaches MIN_PIXELS;
//           otherwise the coordinates publish as 0. When undefined, any
//           skin pixel is a detection and MIN_PIXELS is not used.
module skin_bbox #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int MIN_PIXELS = 16
) (
  input  logic         clk,
  input  logic         rst,
  skin_bbox_if.slave   bus
);

  if (IMG_WIDTH < 2 || IMG_WIDTH > 4095 || IMG_HEIGHT < 2 || IMG_HEIGHT > 4095 ||
      MIN_PIXELS < 0) begin : g_bad_cfg
    $error("skin_bbox: parameter out of range");
  end

  localparam logic [11:0] P_X_LAST = 12'(IMG_WIDTH - 1);
  localparam logic [11:0] P_Y_LAST = 12'(IMG_HEIGHT - 1);
  localparam logic [23:0] P_CNT_MAX = 24'hFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // raster position of the next pixel to be accumulated
  logic [11:0] r_x;
  logic [11:0] r_y;

  // running accumulators of the frame in progress
  logic        r_acc_any;
  logic [11:0] r_acc_xmin;
  logic [11:0] r_acc_xmax;
  logic [11:0] r_acc_ymin;
  logic [11:0] r_acc_ymax;
  logic [23:0] r_acc_count;

  // published result of the last completed frame
  logic [11:0] r_x_min;
  logic [11:0] r_x_max;
  logic [11:0] r_y_min;
  logic [11:0] r_y_max;
  logic [23:0] r_pixel_count;
  logic        r_bbox_found;
  logic        r_bbox_valid;

  logic        w_first_pix;
  logic        w_pix_last;
  logic        w_start;
  logic        w_accum;
  logic        w_publish;
  logic        w_found;

  // frame_start only means something on a valid pixel
  assign w_first_pix = bus.data_in_valid & bus.frame_start;
  assign w_pix_last  = (r_x == P_X_LAST) && (r_y == P_Y_LAST);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_first_pix) w_state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        // a new frame_start aborts the frame in progress and restarts it
        if (w_first_pix) begin
          w_state_nxt = S_ACTIVE;
        end else if (bus.data_in_valid && w_pix_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // DONE lasts one cycle; a frame may start in that very cycle
        w_state_nxt = w_first_pix ? S_ACTIVE : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------------
  always_comb begin
    w_start   = 1'b0;
    w_accum   = 1'b0;
    w_publish = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_start = w_first_pix;
      end
      S_ACTIVE: begin
        w_start = w_first_pix;
        w_accum = bus.data_in_valid & ~bus.frame_start;
      end
      S_DONE: begin
        w_start   = w_first_pix;
        w_publish = 1'b1;
      end
      default: begin
        w_start = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Raster position counters
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x <= 12'd0;
      r_y <= 12'd0;
    end else if (w_start) begin
      // the start pixel itself is (0,0); IMG_WIDTH >= 2 so next is (1,0)
      r_x <= 12'd1;
      r_y <= 12'd0;
    end else if (w_accum) begin
      if (r_x == P_X_LAST) begin
        r_x <= 12'd0;
        r_y <= w_pix_last ? 12'd0 : r_y + 12'd1;
      end else begin
        r_x <= r_x + 12'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Bounding-box and count accumulators
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_any   <= 1'b0;
      r_acc_xmin  <= 12'd0;
      r_acc_xmax  <= 12'd0;
      r_acc_ymin  <= 12'd0;
      r_acc_ymax  <= 12'd0;
      r_acc_count <= 24'd0;
    end else if (w_start) begin
      // start pixel sits at (0,0), so zero coordinates are right either way
      r_acc_any   <= bus.mask_in;
      r_acc_xmin  <= 12'd0;
      r_acc_xmax  <= 12'd0;
      r_acc_ymin  <= 12'd0;
      r_acc_ymax  <= 12'd0;
      r_acc_count <= {23'd0, bus.mask_in};
    end else if (w_accum && bus.mask_in) begin
      r_acc_any <= 1'b1;
      if (!r_acc_any) begin
        r_acc_xmin <= r_x;
        r_acc_xmax <= r_x;
        r_acc_ymin <= r_y;
        r_acc_ymax <= r_y;
      end else begin
        if (r_x < r_acc_xmin) r_acc_xmin <= r_x;
        if (r_x > r_acc_xmax) r_acc_xmax <= r_x;
        if (r_y < r_acc_ymin) r_acc_ymin <= r_y;
        if (r_y > r_acc_ymax) r_acc_ymax <= r_y;
      end
      if (r_acc_count != P_CNT_MAX) r_acc_count <= r_acc_count + 24'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Detection decision
  // ---------------------------------------------------------------------
`ifdef SKIN_BBOX_NOISE_FILTER_EN
  localparam logic [23:0] P_MIN_CNT = 24'(MIN_PIXELS);
  assign w_found = (r_acc_count >= P_MIN_CNT);
`else
  assign w_found = r_acc_any;
`endif

  // ---------------------------------------------------------------------
  // Published result; loads in the DONE cycle, otherwise holds
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x_min       <= 12'd0;
      r_x_max       <= 12'd0;
      r_y_min       <= 12'd0;
      r_y_max       <= 12'd0;
      r_pixel_count <= 24'd0;
      r_bbox_found  <= 1'b0;
      r_bbox_valid  <= 1'b0;
    end else begin
      r_bbox_valid <= w_publish;
      if (w_publish) begin
        r_pixel_count <= r_acc_count;
        r_bbox_found  <= w_found;
        // a rejected (or empty) frame reports a zero box
        r_x_min <= w_found ? r_acc_xmin : 12'd0;
        r_x_max <= w_found ? r_acc_xmax : 12'd0;
        r_y_min <= w_found ? r_acc_ymin : 12'd0;
        r_y_max <= w_found ? r_acc_ymax : 12'd0;
      end
    end
  end

  assign bus.x_min       = r_x_min;
  assign bus.x_max       = r_x_max;
  assign bus.y_min       = r_y_min;
  assign bus.y_max       = r_y_max;
  assign bus.pixel_count = r_pixel_count;
  assign bus.bbox_found  = r_bbox_found;
  assign bus.bbox_valid  = r_bbox_valid;

endmodule
